// File: rtl/uart_fifo_hub.sv
// uart_fifo_hub
//   UART echo hub: every byte received on rx_in is queued in a small FIFO
//   and retransmitted on tx_out in arrival order. tx_hold pauses the
//   transmitter between frames without losing received bytes.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   DATA_BITS     data bits per frame, LSB first (5..9)
//   DEPTH         FIFO entries (power of 2, >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   rx_in       serial input, idle high, asynchronous to clk
//   tx_hold     1 = do not start a new TX frame
//   tx_out      serial output, idle high
//   tx_busy     1 while a TX frame is in progress (start..stop)
//   fifo_level  FIFO entry count, 0..DEPTH
//   overflow    sticky: a received byte was dropped on a full FIFO
//   frame_err   1-clk pulse: stop bit sampled low
//   parity_err  1-clk pulse: even-parity mismatch (UART_HUB_PARITY_EN only)
//
// Build option
//   UART_HUB_PARITY_EN  adds an even-parity bit after the data bits on
//                       both RX and TX and exposes parity_err.
`timescale 1ns/1ps

module uart_fifo_hub #(
    parameter int CLKS_PER_BIT = 139,
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_in,
    input  logic                     tx_hold,
    output logic                     tx_out,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     frame_err
`ifdef UART_HUB_PARITY_EN
    ,
    output logic                     parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_HUB_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // rx_in synchroniser; rxs_d is one more stage used only to see the
    // 1->0 transition that marks a start bit.
    // ------------------------------------------------------------------
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [2:0]           rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick;
    logic                 rx_stop_ok;
    logic                 rx_push;
`ifdef UART_HUB_PARITY_EN
    logic                 rx_par_bad;
`endif

    assign rx_tick    = (rx_cnt == BIT_END);
    assign rx_stop_ok = (rx_state == S_STOP) && rx_tick && rxs;
`ifdef UART_HUB_PARITY_EN
    // A parity failure drops the byte but the frame still runs to STOP.
    assign rx_push = rx_stop_ok && !rx_par_bad;
`else
    assign rx_push = rx_stop_ok;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            frame_err  <= 1'b0;
`ifdef UART_HUB_PARITY_EN
            rx_par_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
`ifdef UART_HUB_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (rx_state)
                S_IDLE: begin
                    if (rxs_d && !rxs) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    // Half a bit in: still low means a real start bit,
                    // high again means a glitch that is silently ignored.
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        rx_idx   <= rx_idx + 1'b1;
                        if (rx_idx == LAST_BIT) begin
`ifdef UART_HUB_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_HUB_PARITY_EN
                S_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= ^{rx_shift, rxs};
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_tick) begin
                        rx_cnt    <= '0;
                        rx_state  <= S_IDLE;
                        frame_err <= !rxs;
`ifdef UART_HUB_PARITY_EN
                        // Reported here so both errors pulse together.
                        parity_err <= rx_par_bad;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit so level = wr - rd covers
    // both empty (0) and full (DEPTH).
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_full, fifo_empty;
    logic                 wr_en, pop;
    logic [2:0]           tx_state;

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_level == FULL_LVL);
    assign fifo_empty = (fifo_level == '0);
    // Full is judged before any same-cycle pop, so a push on a full FIFO
    // is dropped even if the transmitter frees a slot in that cycle.
    assign wr_en      = rx_push && !fifo_full;
    assign pop        = (tx_state == S_IDLE) && !fifo_empty && !tx_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (rx_push && fifo_full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] head;
    logic                 tx_tick;
`ifdef UART_HUB_PARITY_EN
    logic                 tx_par;
`endif

    assign head    = mem[rd_ptr[AW-1:0]];
    assign tx_tick = (tx_cnt == BIT_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
`ifdef UART_HUB_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                S_IDLE: begin
                    // Only reached for at least one clk after STOP, which
                    // gives the extra idle-high clk between frames.
                    if (pop) begin
                        tx_shift <= head;
`ifdef UART_HUB_PARITY_EN
                        tx_par   <= ^head;
`endif
                        tx_state <= S_START;
                        tx_out   <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_out   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        tx_idx <= tx_idx + 1'b1;
                        if (tx_idx == LAST_BIT) begin
`ifdef UART_HUB_PARITY_EN
                            tx_out   <= tx_par;
                            tx_state <= S_PARITY;
`else
                            tx_out   <= 1'b1;
                            tx_state <= S_STOP;
`endif
                        end else begin
                            tx_out   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_HUB_PARITY_EN
                S_PARITY: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_out   <= 1'b1;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    tx_out   <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_hub.sv
`timescale 1ns/1ps

module tb_uart_fifo_hub;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
`ifdef UART_HUB_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLKS = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       tx_hold;
    logic       tx_out;
    logic       tx_busy;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       frame_err;
`ifdef UART_HUB_PARITY_EN
    logic       parity_err;
`endif

    uart_fifo_hub #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .tx_hold    (tx_hold),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err)
`ifdef UART_HUB_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          fe_cnt = 0;
    int          pe_cnt = 0;
    int          lvl_nz = 0;
    logic [7:0]  exp_q[$];
    int unsigned starts[$];
    bit          mon_abort = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (fifo_level != 3'd0) lvl_nz++;
`ifdef UART_HUB_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    // ------------------------------------------------------------------
    // Monitor: decodes tx_out frames at bit centres and checks them
    // against the expected-byte queue.
    // ------------------------------------------------------------------
    bit         m_in_frame = 1'b0;
    bit         m_prev = 1'b1;
    int         m_pos = 0;
    int         m_idx = 0;
    logic [7:0] m_data = '0;
    logic [7:0] m_exp = '0;
    logic       m_par = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_abort) begin
                m_in_frame = 1'b0;
                mon_abort  = 1'b0;
            end else if (!m_in_frame) begin
                if (m_prev && !tx_out) begin
                    m_in_frame = 1'b1;
                    m_pos      = 0;
                    starts.push_back(cyc);
                end
            end else begin
                m_pos++;
            end
            if (m_in_frame && (m_pos % CPB) == CPB / 2) begin
                m_idx = m_pos / CPB;
                if (m_idx == 0)
                    check("mon_start_bit", int'(tx_out), 0);
                else if (m_idx <= DB)
                    m_data[m_idx-1] = tx_out;
`ifdef UART_HUB_PARITY_EN
                else if (m_idx == DB + 1)
                    m_par = tx_out;
`endif
                else begin
                    check("mon_stop_bit", int'(tx_out), 1);
                    check("mon_frame_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        m_exp = exp_q.pop_front();
                        check("mon_data", int'(m_data), int'(m_exp));
`ifdef UART_HUB_PARITY_EN
                        check("mon_parity", int'(m_par), int'(^m_exp));
`endif
                    end
                    m_in_frame = 1'b0;
                end
            end
            m_prev = tx_out;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_b);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_HUB_PARITY_EN
        rx_in = par_b;
        repeat (CPB) @(negedge clk);
`else
        if (par_b === 1'bx) rx_in = 1'b1;
`endif
        rx_in = stop_b;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < 3000), 1);
        repeat (20) @(negedge clk);
    endtask

    // Scratch variables for the main sequence.
    int         n, busy_n, low_n, ns, fe0, pe0, lz0;
    bit         in_low;
    logic [7:0] b;

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : main
        rst = 1'b1;
        rx_in = 1'b1;
        tx_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_out", int'(tx_out), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_frame_err", int'(frame_err), 0);
`ifdef UART_HUB_PARITY_EN
        check("rst_parity_err", int'(parity_err), 0);
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single byte echo, latency and frame timing
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55, 1'b1, 1'b0);
            begin
                n = 0;
                while (fifo_level != 3'd1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("t1_level_rise", int'(fifo_level), 1);
                check("t1_tx_idle_at_push", int'(tx_out), 1);
                @(negedge clk);
                check("t1_level_fall", int'(fifo_level), 0);
                check("t1_tx_start_latency", int'(tx_out), 0);
                busy_n = 0;
                low_n = 0;
                in_low = 1'b1;
                while (tx_busy && busy_n < 400) begin
                    busy_n++;
                    if (in_low && !tx_out) low_n++;
                    else in_low = 1'b0;
                    @(negedge clk);
                end
                check("t1_busy_cycles", busy_n, FRAME_CLKS);
                check("t1_start_bit_len", low_n, CPB);
            end
        join
        wait_drain("t1_drain");

        // 2: hold, fill past full, then release
        tx_hold = 1'b1;
        ns = starts.size();
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i);
            if (i <= 4) exp_q.push_back(b);
            send_byte(b, 1'b1, ^b);
            if (i == 4) begin
                check("t2_level_full", int'(fifo_level), 4);
                check("t2_no_overflow_yet", int'(overflow), 0);
            end
            if (i == 5) begin
                check("t2_overflow_set", int'(overflow), 1);
                check("t2_level_held", int'(fifo_level), 4);
            end
        end
        check("t2_tx_quiet_on_hold", starts.size(), ns);
        tx_hold = 1'b0;
        wait_drain("t2_drain");
        check("t2_frame_count", starts.size(), ns + 4);
        if (starts.size() == ns + 4) begin
            for (int k = 0; k < 3; k++)
                check("t2_frame_spacing", int'(starts[ns+k+1] - starts[ns+k]), FRAME_CLKS + 1);
        end
        check("t2_overflow_sticky", int'(overflow), 1);

        // 3: stop bit driven low
        fe0 = fe_cnt; pe0 = pe_cnt; lz0 = lvl_nz; ns = starts.size();
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("t3_frame_err_pulses", fe_cnt - fe0, 1);
        check("t3_parity_err_pulses", pe_cnt - pe0, 0);
        check("t3_level_stays_0", lvl_nz - lz0, 0);
        check("t3_tx_quiet", starts.size(), ns);

        // 4: short glitch, then a valid byte
        fe0 = fe_cnt; lz0 = lvl_nz;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_glitch_no_err", fe_cnt - fe0, 0);
        check("t4_glitch_no_push", lvl_nz - lz0, 0);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1, 1'b0);
        wait_drain("t4_drain");

        // 5: reset mid data bit 3 with 2 bytes still queued
        tx_hold = 1'b1;
        exp_q.push_back(8'h11); send_byte(8'h11, 1'b1, 1'b0);
        exp_q.push_back(8'h22); send_byte(8'h22, 1'b1, 1'b0);
        exp_q.push_back(8'h33); send_byte(8'h33, 1'b1, 1'b0);
        check("t5_level_3", int'(fifo_level), 3);
        tx_hold = 1'b0;
        n = 0;
        while (tx_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_frame_started", int'(tx_out), 0);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        #2;
        rst = 1'b1;
        mon_abort = 1'b1;
        #1;
        check("t5_async_tx_out", int'(tx_out), 1);
        check("t5_async_tx_busy", int'(tx_busy), 0);
        check("t5_async_level", int'(fifo_level), 0);
        check("t5_async_overflow", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ns = starts.size();
        repeat (300) @(negedge clk);
        check("t5_nothing_sent", starts.size(), ns);
        check("t5_level_after", int'(fifo_level), 0);

`ifdef UART_HUB_PARITY_EN
        // 6: parity generation and checking
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1, 1'b1);
        wait_drain("t6_drain");
        fe0 = fe_cnt; pe0 = pe_cnt; lz0 = lvl_nz;
        send_byte(8'h07, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check("t6_parity_err_pulses", pe_cnt - pe0, 1);
        check("t6_no_frame_err", fe_cnt - fe0, 0);
        check("t6_level_stays_0", lvl_nz - lz0, 0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
